branch_pc_ctrl: RTL and testbench

- Sequences the PC-update path of the multicycle MIPS core for control-transfer instructions (beq, bne, bgt, ble, j, jal, jr).
- Drives the branch-condition mux select, ALU compare request, and PC write enables; captures the resolved branch outcome.
- Keeps saturating branch and taken-branch statistics counters.
- Sits between the main control FSM, which hands it a decoded instruction, and the datapath: ALU flags in, PC write controls out.

---
 rtl/branch_pc_ctrl_if.sv | 35 +++
 rtl/branch_pc_ctrl.sv | 146 ++++++++++++++
 tb/tb_branch_pc_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pc_ctrl_if.sv
// Handshake and PC-control bundle between the main FSM/datapath (master) and branch_pc_ctrl (slave).
// Carries the decoded instruction fields and ALU flags in, and the PC write controls and statistics out.
interface branch_pc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero_flag;
  logic             gt_flag;
  logic             busy;
  logic             done;
  logic             err;
  logic             alu_sub;
  logic [1:0]       pcwc_sel;
  logic             pc_write_cond;
  logic             pc_write;
  logic [1:0]       pc_source;
  logic             ra_write;
  logic             taken;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output start, opcode, funct, zero_flag, gt_flag,
    input  busy, done, err, alu_sub, pcwc_sel, pc_write_cond, pc_write,
           pc_source, ra_write, taken, branch_count, taken_count
  );

  modport slave (
    input  start, opcode, funct, zero_flag, gt_flag,
    output busy, done, err, alu_sub, pcwc_sel, pc_write_cond, pc_write,
           pc_source, ra_write, taken, branch_count, taken_count
  );
endinterface

// File: rtl/branch_pc_ctrl.sv
// PC-update sequencer for beq/bne/bgt/ble/j/jal/jr: one action cycle, then a done (or err) pulse.
// Latency start->done is 2 cycles; start is ignored while busy, so issue spacing is at least 3 cycles.
module branch_pc_ctrl #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  branch_pc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COMPARE, JUMP, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel_q, src_q;
  logic             jal_q;
  logic             taken_q;
  logic [CNT_W-1:0] bc_q, tc_q;

  logic             is_branch, is_jump, dec_jal, cond;
  logic [1:0]       dec_sel, dec_src;

  logic             busy_o, done_o, err_o, alu_sub_o, pwc_o, pw_o, ra_o;
  logic [1:0]       pcwc_sel_o, pc_source_o;

  always_comb begin
    is_branch = 1'b0;
    is_jump   = 1'b0;
    dec_jal   = 1'b0;
    dec_sel   = 2'b00;
    dec_src   = 2'b00;
    case (bus.opcode)
      6'h04: begin is_branch = 1'b1; dec_sel = 2'b01; end
      6'h05: begin is_branch = 1'b1; dec_sel = 2'b00; end
      6'h07: begin is_branch = 1'b1; dec_sel = 2'b10; end
      6'h06: begin is_branch = 1'b1; dec_sel = 2'b11; end
      6'h02: begin is_jump = 1'b1; dec_src = 2'b10; end
      6'h03: begin is_jump = 1'b1; dec_src = 2'b10; dec_jal = 1'b1; end
      6'h00: begin
        if (bus.funct == 6'h08) begin
          is_jump = 1'b1;
          dec_src = 2'b11;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_branch)    state_nxt = COMPARE;
          else if (is_jump) state_nxt = JUMP;
          else              state_nxt = ERR;
        end
      end
      COMPARE: state_nxt = DONE;
      JUMP:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction fields are only captured on acceptance, so starts while busy cannot disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= 2'b00;
      src_q <= 2'b00;
      jal_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sel_q <= dec_sel;
      src_q <= dec_src;
      jal_q <= dec_jal;
    end
  end

  always_comb begin
    case (sel_q)
      2'b00:   cond = ~bus.zero_flag;
      2'b01:   cond = bus.zero_flag;
      2'b10:   cond = bus.gt_flag;
      default: cond = bus.zero_flag | ~bus.gt_flag;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q <= 1'b0;
      bc_q    <= '0;
      tc_q    <= '0;
    end else if (state == COMPARE) begin
      taken_q <= cond;
      if (bc_q != '1)         bc_q <= bc_q + 1'b1;
      if (cond && tc_q != '1) tc_q <= tc_q + 1'b1;
    end
  end

  always_comb begin
    busy_o      = (state != IDLE);
    done_o      = 1'b0;
    err_o       = 1'b0;
    alu_sub_o   = 1'b0;
    pwc_o       = 1'b0;
    pw_o        = 1'b0;
    ra_o        = 1'b0;
    pcwc_sel_o  = 2'b00;
    pc_source_o = 2'b00;
    case (state)
      COMPARE: begin
        alu_sub_o   = 1'b1;
        pwc_o       = 1'b1;
        pcwc_sel_o  = sel_q;
        pc_source_o = 2'b01;
      end
      JUMP: begin
        pw_o        = 1'b1;
        pc_source_o = src_q;
        ra_o        = jal_q;
      end
      DONE:    done_o = 1'b1;
      ERR:     err_o  = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy          = busy_o;
  assign bus.done          = done_o;
  assign bus.err           = err_o;
  assign bus.alu_sub       = alu_sub_o;
  assign bus.pcwc_sel      = pcwc_sel_o;
  assign bus.pc_write_cond = pwc_o;
  assign bus.pc_write      = pw_o;
  assign bus.pc_source     = pc_source_o;
  assign bus.ra_write      = ra_o;
  assign bus.taken         = taken_q;
  assign bus.branch_count  = bc_q;
  assign bus.taken_count   = tc_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Random/directed bench for branch_pc_ctrl: two instances (16-bit and 2-bit counters) share stimulus;
// a driver pushes expected outcomes into a scoreboard and a negedge monitor pops and compares.
module tb_branch_pc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] opcode, funct;
  logic       zero_flag, gt_flag;

  always #5 clk = ~clk;

  branch_pc_ctrl_if #(.CNT_W(16)) bus16 ();
  branch_pc_ctrl_if #(.CNT_W(2))  bus2 ();

  assign bus16.start = start;     assign bus2.start = start;
  assign bus16.opcode = opcode;   assign bus2.opcode = opcode;
  assign bus16.funct = funct;     assign bus2.funct = funct;
  assign bus16.zero_flag = zero_flag; assign bus2.zero_flag = zero_flag;
  assign bus16.gt_flag = gt_flag; assign bus2.gt_flag = gt_flag;

  branch_pc_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  branch_pc_ctrl #(.CNT_W(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    int kind;  // 0 branch, 1 jump, 2 unsupported
    int sel;
    int src;
    int ra;
    int tk;
    int bc;
    int tc;
    int bc2;
    int tc2;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int   mdl_tk, mdl_bc, mdl_tc, mdl_bc2, mdl_tc2;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    int   last_tk, last_bc, last_tc, last_bc2, last_tc2;
    bit   act_pending;
    int   ctl;
    exp_t e;
    last_tk = 0; last_bc = 0; last_tc = 0; last_bc2 = 0; last_tc2 = 0;
    act_pending = 0;
    forever begin
      @(negedge clk);
      ctl = int'({bus16.alu_sub, bus16.pc_write_cond, bus16.pc_write, bus16.ra_write,
                  bus16.pc_source, bus16.pcwc_sel});
      if (reset) begin
        sb.delete();
        last_tk = 0; last_bc = 0; last_tc = 0; last_bc2 = 0; last_tc2 = 0;
        act_pending = 0;
      end else begin
        if (act_pending) chk("done_latency", int'(bus16.done), 1);
        act_pending = 0;
        if (!bus16.busy) begin
          chk("idle_ctl", ctl, 0);
          chk("idle_pulses", int'({bus16.done, bus16.err}), 0);
          chk("idle_taken", int'(bus16.taken), last_tk);
          chk("idle_bc16", int'(bus16.branch_count), last_bc);
          chk("idle_tc16", int'(bus16.taken_count), last_tc);
          chk("idle_bc2", int'(bus2.branch_count), last_bc2);
          chk("idle_tc2", int'(bus2.taken_count), last_tc2);
        end
        if (bus16.alu_sub || bus16.pc_write_cond || bus16.pc_write || bus16.ra_write) begin
          if (sb.size() == 0) chk("action_unexpected", 1, 0);
          else begin
            e = sb[0];
            chk("act_alu_sub", int'(bus16.alu_sub), int'(e.kind == 0));
            chk("act_pc_write_cond", int'(bus16.pc_write_cond), int'(e.kind == 0));
            chk("act_pc_write", int'(bus16.pc_write), int'(e.kind == 1));
            chk("act_pcwc_sel", int'(bus16.pcwc_sel), (e.kind == 0) ? e.sel : 0);
            chk("act_pc_source", int'(bus16.pc_source), e.src);
            chk("act_ra_write", int'(bus16.ra_write), e.ra);
            chk("act_busy", int'(bus16.busy), 1);
            act_pending = 1;
          end
        end
        if (bus16.done) begin
          if (sb.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("done_kind_ok", int'(e.kind != 2), 1);
            chk("done_ctl", ctl, 0);
            chk("done_taken", int'(bus16.taken), e.tk);
            chk("done_bc16", int'(bus16.branch_count), e.bc);
            chk("done_tc16", int'(bus16.taken_count), e.tc);
            chk("done_bc2", int'(bus2.branch_count), e.bc2);
            chk("done_tc2", int'(bus2.taken_count), e.tc2);
            last_tk = e.tk; last_bc = e.bc; last_tc = e.tc;
            last_bc2 = e.bc2; last_tc2 = e.tc2;
          end
        end
        if (bus16.err) begin
          if (sb.size() == 0) chk("err_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("err_kind", e.kind, 2);
            chk("err_ctl", ctl, 0);
            chk("err_done", int'(bus16.done), 0);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic junk();
    start  = ($urandom_range(0, 3) != 0);
    opcode = ($urandom_range(0, 1) == 1) ? 6'h02 : 6'($urandom);
    funct  = 6'($urandom);
  endtask

  task automatic issue(input int op, input bit fz, input bit fg);
    exp_t       e;
    bit         c;
    logic [5:0] opc, fn;
    fn = 6'($urandom);
    case (op)
      0: opc = 6'h04;
      1: opc = 6'h05;
      2: opc = 6'h07;
      3: opc = 6'h06;
      4: opc = 6'h02;
      5: opc = 6'h03;
      6: begin opc = 6'h00; fn = 6'h08; end
      7: begin
        do opc = 6'($urandom); while (opc inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07});
      end
      8: begin
        opc = 6'h00;
        do fn = 6'($urandom); while (fn == 6'h08);
      end
      default: begin opc = 6'h00; fn = 6'h20; end
    endcase

    e = '{default: 0};
    if (op <= 3) begin
      e.kind = 0;
      e.src  = 1;
      case (op)
        0: begin e.sel = 1; c = fz; end        // beq: equal
        1: begin e.sel = 0; c = !fz; end       // bne: not equal
        2: begin e.sel = 2; c = fg; end        // bgt: A > B
        default: begin e.sel = 3; c = fz || !fg; end  // ble: A <= B
      endcase
      mdl_tk  = int'(c);
      mdl_bc  = sat(mdl_bc, 65535);
      mdl_bc2 = sat(mdl_bc2, 3);
      if (c) begin
        mdl_tc  = sat(mdl_tc, 65535);
        mdl_tc2 = sat(mdl_tc2, 3);
      end
    end else if (op <= 6) begin
      e.kind = 1;
      e.src  = (op == 6) ? 3 : 2;
      e.ra   = (op == 5) ? 1 : 0;
    end else begin
      e.kind = 2;
    end
    e.tk = mdl_tk; e.bc = mdl_bc; e.tc = mdl_tc; e.bc2 = mdl_bc2; e.tc2 = mdl_tc2;
    sb.push_back(e);

    start = 1'b1; opcode = opc; funct = fn;
    zero_flag = 1'($urandom); gt_flag = 1'($urandom);
    @(posedge clk); #1;
    junk();
    zero_flag = fz; gt_flag = fg;
    if (e.kind != 2) begin
      @(posedge clk); #1;
      junk();
      zero_flag = 1'($urandom); gt_flag = 1'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    zero_flag = 1'($urandom); gt_flag = 1'($urandom);
  endtask

  task automatic reset_mid_compare();
    start = 1'b1; opcode = 6'h04; funct = 6'($urandom); zero_flag = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_tk = 0; mdl_bc = 0; mdl_tc = 0; mdl_bc2 = 0; mdl_tc2 = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int dir_op[13] = '{0, 3, 2, 5, 6, 9, 4, 0, 0, 0, 0, 0, 1};
    bit dir_z[13]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    bit dir_g[13]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    reset = 1'b1; start = 1'b0; opcode = '0; funct = '0; zero_flag = 1'b0; gt_flag = 1'b0;
    mdl_tk = 0; mdl_bc = 0; mdl_tc = 0; mdl_bc2 = 0; mdl_tc2 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    foreach (dir_op[i]) issue(dir_op[i], dir_z[i], dir_g[i]);
    reset_mid_compare();

    for (int n = 0; n < 250; n++) begin
      issue(int'($urandom_range(0, 8)), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    reset_mid_compare();
    for (int n = 0; n < 30; n++) issue(int'($urandom_range(0, 8)), 1'($urandom), 1'($urandom));

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
